// File: rtl/msk_aes128_sb_sched_pkg.sv
// ---------------------------------------------------------------------------
// msk_aes128_sb_sched_pkg
// Shared build parameters for the masked SubBytes layer and its scheduler.
// Both the scheduler and the S-box layer import this package, so pipeline
// latency and randomness staging cannot drift apart.
//   SB_LAT_BP       : S-box pipeline latency, input to output (cycles)
//   SB_RND_MASK_BP  : per-stage randomness use (bus0 @ stage 0, bus1 @ stage 1,
//                     bus2 @ stage 2, no randomness in the last stage)
//   clog2()         : ceil(log2(value)), used for counter widths
// ---------------------------------------------------------------------------
package msk_aes128_sb_sched_pkg;

  localparam int         SB_LAT_BP      = 4;
  localparam logic [3:0] SB_RND_MASK_BP = 4'b0111;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/msk_aes128_sb_sched_valid_pipe.sv
// ---------------------------------------------------------------------------
// msk_aes128_sb_sched_valid_pipe
// LAT-deep valid shift register shadowing the free-running S-box pipeline.
// Bit k is set when S-box stage k+1 holds a live token this cycle.
// Ports:
//   clk    in   clock
//   nrst   in   synchronous active-high reset (clears all tokens)
//   din    in   token entering stage 0 this cycle
//   vpipe  out  [LAT-1:0] token occupancy, registered
//   count  out  [IW-1:0]  popcount of vpipe
// ---------------------------------------------------------------------------
module msk_aes128_sb_sched_valid_pipe #(
  parameter int LAT = 4,
  parameter int IW  = 3
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           din,
  output logic [LAT-1:0] vpipe,
  output logic [IW-1:0]  count
);

  always_ff @(posedge clk) begin
    if (nrst) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[LAT-2:0], din};
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < LAT; i++) begin
      count = count + IW'(vpipe[i]);
    end
  end

endmodule

// File: rtl/msk_aes128_sb_sched.sv
// ---------------------------------------------------------------------------
// msk_aes128_sb_sched
// Issue and occupancy controller for the 128-bit masked SubBytes layer
// (16 parallel masked bitsliced S-boxes, free-running pipeline).
// The S-box pipeline cannot stall, so a state is only issued when input,
// fresh randomness and a downstream buffer credit are all available. The
// credit is reserved at issue, which guarantees every in-flight token a slot
// when it emerges LAT cycles later.
//
// Optional build macro: MSKAES_SB_RND_CHECK_EN
//   defined   : err_rnd latches when an in-flight stage needs randomness
//               while rnd_valid is low (cleared only by reset)
//   undefined : err_rnd tied 0, no checking logic
//
// Ports:
//   clk        in   clock
//   nrst       in   synchronous active-high reset
//   in_valid   in   shared state presented at the S-box layer input
//   in_ready   out  issue allowed this cycle (combinational)
//   sb_issue   out  in_valid & in_ready
//   rnd_valid  in   PRNG outputs are fresh this cycle
//   rnd_next   out  PRNG advances at this edge
//   out_valid  out  S-box layer output valid this cycle
//   credit_ret in   downstream buffer freed one entry
//   inflight   out  number of live tokens in the pipeline
//   busy       out  inflight != 0
//   err_rnd    out  sticky randomness-starvation flag
// ---------------------------------------------------------------------------
module msk_aes128_sb_sched
  import msk_aes128_sb_sched_pkg::*;
#(
  parameter int             D        = 2,
  parameter int             LAT      = SB_LAT_BP,
  parameter logic [LAT-1:0] RND_MASK = LAT'(SB_RND_MASK_BP),
  parameter int             CREDITS  = 2,
  localparam int            IW       = clog2(LAT + 1),
  localparam int            CW       = clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          sb_issue,
  input  logic          rnd_valid,
  output logic          rnd_next,
  output logic          out_valid,
  input  logic          credit_ret,
  output logic [IW-1:0] inflight,
  output logic          busy,
  output logic          err_rnd
);

  // Share count only matters to the datapath; it is checked here so a bad
  // configuration fails at elaboration rather than silently.
  if (D < 1) begin : g_bad_d
    $error("D (share count) must be >= 1");
  end
  if (LAT < 2) begin : g_bad_lat
    $error("LAT must be >= 2");
  end
  if (CREDITS < 1) begin : g_bad_credits
    $error("CREDITS must be >= 1");
  end

  logic [LAT-1:0] vpipe;
  logic [LAT-1:0] occ;
  logic [LAT-1:0] need;
  logic [CW-1:0]  credits;
  logic           credits_full;

  msk_aes128_sb_sched_valid_pipe #(
    .LAT (LAT),
    .IW  (IW)
  ) u_vpipe (
    .clk   (clk),
    .nrst  (nrst),
    .din   (sb_issue),
    .vpipe (vpipe),
    .count (inflight)
  );

  assign credits_full = (credits == CW'(CREDITS));

  // Credits are decremented at issue, so the register itself is the number
  // of unreserved buffer slots.
  assign in_ready  = rnd_valid & (credits != '0) & ~nrst;
  assign sb_issue  = in_valid & in_ready;
  assign out_valid = vpipe[LAT-1];
  assign busy      = (inflight != '0);

  // Stage 0 is occupied by the token being issued now; stage k by vpipe[k-1].
  assign occ      = {vpipe[LAT-2:0], sb_issue};
  assign need     = occ & RND_MASK;
  assign rnd_next = |need;

  // Issue and return in the same cycle cancel; a return at full is dropped.
  always_ff @(posedge clk) begin
    if (nrst) begin
      credits <= CW'(CREDITS);
    end else if (sb_issue && !credit_ret) begin
      credits <= credits - CW'(1);
    end else if (!sb_issue && credit_ret && !credits_full) begin
      credits <= credits + CW'(1);
    end
  end

`ifdef MSKAES_SB_RND_CHECK_EN
  // Stage 0 is excluded: without rnd_valid nothing is issued, so only
  // tokens already in flight can be starved.
  logic need_inflight;
  assign need_inflight = |need[LAT-1:1];

  always_ff @(posedge clk) begin
    if (nrst) begin
      err_rnd <= 1'b0;
    end else if (!rnd_valid && need_inflight) begin
      err_rnd <= 1'b1;
    end
  end
`else
  assign err_rnd = 1'b0;
`endif

endmodule

// File: tb/tb_msk_aes128_sb_sched.sv
module tb_msk_aes128_sb_sched;

`ifdef MSKAES_SB_RND_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // default instance: LAT=4, CREDITS=2
  logic       nrst, in_valid, in_ready, sb_issue, rnd_valid, rnd_next;
  logic       out_valid, credit_ret, busy, err_rnd;
  logic [2:0] inflight;

  // streaming instance: one extra credit over LAT, because a credit returns
  // in the same cycle as out_valid and issue needs credits > 0 that cycle
  logic       nrst_s, in_valid_s, in_ready_s, sb_issue_s, rnd_valid_s, rnd_next_s;
  logic       out_valid_s, credit_ret_s, busy_s, err_rnd_s;
  logic [2:0] inflight_s;

  int n_err = 0;
  int n_chk = 0;

  msk_aes128_sb_sched u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sb_issue   (sb_issue),
    .rnd_valid  (rnd_valid),
    .rnd_next   (rnd_next),
    .out_valid  (out_valid),
    .credit_ret (credit_ret),
    .inflight   (inflight),
    .busy       (busy),
    .err_rnd    (err_rnd)
  );

  msk_aes128_sb_sched #(.CREDITS(5)) u_dut_stream (
    .clk        (clk),
    .nrst       (nrst_s),
    .in_valid   (in_valid_s),
    .in_ready   (in_ready_s),
    .sb_issue   (sb_issue_s),
    .rnd_valid  (rnd_valid_s),
    .rnd_next   (rnd_next_s),
    .out_valid  (out_valid_s),
    .credit_ret (credit_ret_s),
    .inflight   (inflight_s),
    .busy       (busy_s),
    .err_rnd    (err_rnd_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    next_cycle();
    nrst = 1'b0;
  endtask

  // burst table (bit t = cycle t)
  logic [7:0] e_issue = 8'b0000_0011;
  logic [7:0] e_rdy   = 8'b0000_0011;
  logic [7:0] e_ov    = 8'b0011_0000;
  logic [7:0] e_rn    = 8'b0000_1111;
  int         e_inf [8] = '{0, 1, 2, 2, 2, 1, 0, 0};
  // single-issue randomness-gap table
  logic [5:0] g_rn    = 6'b00_0111;
  logic [5:0] g_ov    = 6'b01_0000;
  logic [5:0] g_err   = 6'b11_1000;

  initial begin
    nrst = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0; credit_ret = 1'b0;
    nrst_s = 1'b1; in_valid_s = 1'b0; rnd_valid_s = 1'b0; credit_ret_s = 1'b0;
    next_cycle();
    next_cycle();
    nrst = 1'b0; nrst_s = 1'b0;

    // reset state
    rnd_valid = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_inflight",  32'(inflight), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_rnd_next",  32'(rnd_next), 0);
    chk("rst_err_rnd",   32'(err_rnd), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
    chk("rst_credits",   32'(u_dut.credits), 2);
    next_cycle();

    // burst until credits run out
    in_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk($sformatf("burst_issue_t%0d", t), 32'(sb_issue),  32'(e_issue[t]));
      chk($sformatf("burst_rdy_t%0d", t),   32'(in_ready),  32'(e_rdy[t]));
      chk($sformatf("burst_ov_t%0d", t),    32'(out_valid), 32'(e_ov[t]));
      chk($sformatf("burst_rn_t%0d", t),    32'(rnd_next),  32'(e_rn[t]));
      chk($sformatf("burst_inf_t%0d", t),   32'(inflight),  32'(e_inf[t]));
      chk($sformatf("burst_busy_t%0d", t),  32'(busy),      32'(e_inf[t] != 0));
      next_cycle();
    end
    in_valid = 1'b0;

    // credit accounting: 0 -> 1, issue+return holds 1, then refill and saturate
    credit_ret = 1'b1;
    next_cycle();
    chk("cred_ret_to1", 32'(u_dut.credits), 1);
    in_valid = 1'b1;
    @(negedge clk);
    chk("cred_sim_issue", 32'(sb_issue), 1);
    next_cycle();
    chk("cred_sim_hold", 32'(u_dut.credits), 1);
    in_valid = 1'b0;
    next_cycle();
    chk("cred_ret_to2", 32'(u_dut.credits), 2);
    next_cycle();
    chk("cred_saturate", 32'(u_dut.credits), 2);
    credit_ret = 1'b0;

    // no randomness, idle pipe
    do_reset();
    rnd_valid = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("nornd_in_ready", 32'(in_ready), 0);
    chk("nornd_issue",    32'(sb_issue), 0);
    chk("nornd_rnd_next", 32'(rnd_next), 0);
    next_cycle();
    chk("nornd_err",      32'(err_rnd), 0);
    chk("nornd_inflight", 32'(inflight), 0);
    in_valid = 1'b0;

    // single issue, randomness missing at t=2
    do_reset();
    for (int t = 0; t < 6; t++) begin
      in_valid  = (t == 0);
      rnd_valid = (t != 2);
      @(negedge clk);
      if (t == 0) chk("gap_issue", 32'(sb_issue), 1);
      chk($sformatf("gap_rn_t%0d", t),  32'(rnd_next),  32'(g_rn[t]));
      chk($sformatf("gap_ov_t%0d", t),  32'(out_valid), 32'(g_ov[t]));
      chk($sformatf("gap_err_t%0d", t), 32'(err_rnd),   32'(g_err[t] & ERR_ON));
      next_cycle();
    end
    rnd_valid = 1'b1;

    // reset mid-flight discards tokens
    do_reset();
    chk("midrst_err_cleared", 32'(err_rnd), 0);
    in_valid = 1'b1;
    next_cycle();
    next_cycle();
    chk("midrst_inf_pre", 32'(inflight), 2);
    nrst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy_in_rst", 32'(in_ready), 0);
    next_cycle();
    nrst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_inf_t3", 32'(inflight), 0);
    chk("midrst_cred_t3", 32'(u_dut.credits), 2);
    chk("midrst_ov_t3", 32'(out_valid), 0);
    next_cycle();
    @(negedge clk);
    chk("midrst_ov_t4", 32'(out_valid), 0);
    next_cycle();
    @(negedge clk);
    chk("midrst_ov_t5", 32'(out_valid), 0);
    next_cycle();

    // sustained stream, credit returned with every output
    in_valid_s  = 1'b1;
    rnd_valid_s = 1'b1;
    for (int t = 0; t < 12; t++) begin
      credit_ret_s = out_valid_s;
      @(negedge clk);
      chk($sformatf("strm_issue_t%0d", t), 32'(sb_issue_s),  1);
      chk($sformatf("strm_ov_t%0d", t),    32'(out_valid_s), 32'(t >= 4));
      chk($sformatf("strm_inf_t%0d", t),   32'(inflight_s),  32'((t < 4) ? t : 4));
      next_cycle();
    end
    in_valid_s   = 1'b0;
    credit_ret_s = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
